// File: rtl/tx_pixel_drain.sv
// tx_pixel_drain: elastic buffer between an edge-detector pixel stream and a
// UART TX FIFO. Each frame of FRAME_PIXELS pixels is preceded by SYNC_BYTE.
// The producer cannot be stalled; pixels arriving with a full buffer and no
// concurrent drain are dropped and flagged on the sticky overflow output.
module tx_pixel_drain #(
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 16,
  parameter int                FRAME_PIXELS = 4096,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [DATA_W-1:0]          pixel_in,
  input  logic                       pixel_in_valid,
  input  logic                       tx_full,
  output logic                       tx_wr,
  output logic [DATA_W-1:0]          tx_wr_data,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            state_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [CW-1:0]     pix_cnt_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic buf_full;
  logic buf_empty;
  logic sync_wr;
  logic pop;
  logic push;
  logic drop;
  logic last_pop;

  // Handshake decisions: writes depend only on registered state and tx_full,
  // so the TX FIFO never sees a write while it reports full.
  always_comb begin
    buf_full  = (level_reg == FULL_LVL);
    buf_empty = (level_reg == '0);
    sync_wr   = (state_reg == SYNC) && !tx_full;
    pop       = (state_reg == STREAM) && !buf_empty && !tx_full;
    push      = pixel_in_valid && (!buf_full || pop);
    drop      = pixel_in_valid && buf_full && !pop;
    last_pop  = pop && (pix_cnt_reg == LAST_PIX);
  end

  // TX write port; data is forced to zero when no write is issued.
  always_comb begin
    tx_wr      = sync_wr || pop;
    tx_wr_data = '0;
    if (sync_wr) begin
      tx_wr_data = SYNC_BYTE;
    end else if (pop) begin
      tx_wr_data = mem[rd_ptr_reg];
    end
  end

  assign frame_done = last_pop;
  assign overflow   = overflow_reg;
  assign level      = level_reg;

  // Buffer storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= pixel_in;
    end
  end

  // Buffer pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Frame sequencer: sync marker first, then FRAME_PIXELS buffered pixels.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!buf_empty) begin
            state_reg <= SYNC;
          end
        end
        SYNC: begin
          if (sync_wr) begin
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (last_pop) begin
            pix_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else if (pop) begin
            pix_cnt_reg <= pix_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          pix_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/tx_pixel_drain.md
TX_PIXEL_DRAIN -- requirements
Module: tx_pixel_drain

Interface
REQ-001 Parameter DATA_W, default 8, pixel and UART byte width.
REQ-002 Parameter DEPTH, default 16, elastic buffer entries (power of two, >=4).
REQ-003 Parameter FRAME_PIXELS, default 4096, pixels per frame (>=1).
REQ-004 Parameter SYNC_BYTE, default 8'hA5, frame marker byte sent before each frame.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rstN  input  1  asynchronous, active-low reset.
REQ-007 pixel_in  input  DATA_W  edge-detector output pixel.
REQ-008 pixel_in_valid  input  1  pixel_in valid this cycle; no backpressure to the producer.
REQ-009 tx_full  input  1  UART TX FIFO full.
REQ-010 tx_wr  output  1  TX FIFO write strobe.
REQ-011 tx_wr_data  output  DATA_W  byte to TX FIFO.
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
REQ-013 overflow  output  1  sticky; a pixel was dropped.
REQ-014 level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-015 Internal FIFO of DEPTH x DATA_W decouples pixel_in_valid from tx_full.
REQ-016 Push when pixel_in_valid and (buffer not full or pop in same cycle).
REQ-017 Simultaneous push and pop at full: both occur, level unchanged, no drop.
REQ-018 Push at full without pop: pixel discarded, overflow set to 1 next edge, stays 1 until reset.
REQ-019 Pointers wrap modulo DEPTH; level ranges 0..DEPTH exactly.
REQ-020 FSM states IDLE, SYNC, STREAM.
REQ-021 IDLE: no writes; level>0 -> SYNC next cycle.
REQ-022 SYNC: if !tx_full, tx_wr=1, tx_wr_data=SYNC_BYTE, -> STREAM; if tx_full, hold SYNC, tx_wr=0.
REQ-023 STREAM: if level>0 and !tx_full, tx_wr=1, tx_wr_data=buffer head, pop same cycle, pixel counter +1.
REQ-024 STREAM with level==0 or tx_full: tx_wr=0, no pop, state held.
REQ-025 tx_wr and tx_wr_data are combinational from registered state, pointers and tx_full; no registered write delay.
REQ-026 tx_wr never asserted in a cycle where tx_full=1.
REQ-027 Pixel counter width $clog2(FRAME_PIXELS+1); on the pop of pixel FRAME_PIXELS: counter cleared, frame_done=1 that same cycle, next state IDLE.
REQ-028 Pixel arrival to first tx_wr latency: 2 cycles from IDLE with empty buffer and tx_full=0 (SYNC write, then pixel write); 1 cycle mid-frame.
REQ-029 Pixels arriving during SYNC or after a frame ends are buffered; the next frame begins with a fresh SYNC_BYTE.
REQ-030 tx_wr_data is 0 whenever tx_wr=0.

Reset
REQ-031 rstN low at any time, including mid-frame: state IDLE, pointers 0, level 0, pixel counter 0, overflow 0, tx_wr 0, tx_wr_data 0, frame_done 0, immediately (asynchronous).
REQ-032 Buffered pixels are lost on reset; first write after rstN release is SYNC_BYTE.
REQ-033 Deassertion is sampled synchronously; first state change no earlier than the first rising edge after rstN high.

Verification
REQ-034 FRAME_PIXELS=4, tx_full=0, pixels 0x10,0x20,0x30,0x40 on consecutive cycles -> tx bytes A5,10,20,30,40; frame_done on the 0x40 write cycle; return to IDLE.
REQ-035 tx_full=1 for 20 cycles while 16 pixels arrive -> level=16, overflow=0, no tx_wr; release -> A5 then all 16 pixels in order.
REQ-036 17th pixel pushed with buffer full and tx_full=1 -> pixel dropped, overflow=1 held, level=16.
REQ-037 Buffer full, tx_full=0, STREAM, pixel_in_valid=1 -> simultaneous push/pop, level stays 16, overflow=0.
REQ-038 Two back-to-back 4-pixel frames -> A5,p0..p3,A5,p4..p7; two frame_done pulses.
REQ-039 rstN pulsed low after 2 pixels of a frame -> all outputs 0 immediately; next pixel produces A5 then that pixel.
